cam_cfg_sequencer: RTL and testbench
====================================

Name: cam_cfg_sequencer

Overview:
Sequences power-up configuration of the camera sensor over the SCCB/I2C write master. Walks a 24-bit register table {reg_addr[15:0], data[7:0]}, issuing one write request per entry. Supports embedded delay and end markers, NACK retry and sticky done/error status. Sits between the top-level init control and the I2C byte-write master.

Parameters:
ADDR_W, 6, table index width (table depth 2**ADDR_W)
DEV_ADDR, 7'h12, 7-bit sensor device address driven on wr_dev
BOOT_WAIT, 1000, idle cycles after start before first fetch (sensor power-up)
DELAY_UNIT, 1000, cycles per count of a delay entry
GAP_CYCLES, 4, bus-free cycles between consecutive transactions
MAX_RETRY, 3, re-issues of a NACKed entry before error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  1-cycle pulse; begin sequence (ignored while busy)
tbl_addr  out  ADDR_W  table read index
tbl_data  in  24  table word for tbl_addr presented in previous cycle
wr_req  out  1  write request, held until wr_done
wr_dev  out  7  device address (= DEV_ADDR)
wr_reg  out  16  register address, stable while wr_req
wr_data  out  8  register data, stable while wr_req
wr_done  in  1  1-cycle pulse: transaction finished
wr_nack  in  1  qualifies wr_done: slave NACKed
busy  out  1  sequence in progress
done  out  1  sticky: table completed
err  out  1  sticky: retries exhausted
err_index  out  ADDR_W  index of failing entry

Behaviour:
- Reset: state IDLE; tbl_addr=0, wr_req=0, wr_reg=0, wr_data=0, busy=0, done=0, err=0, err_index=0, retry=0. All outputs registered; reset mid-transaction drops wr_req immediately.
- Markers: tbl_data==24'hFFFFFF -> end; tbl_data[23:8]==16'hFFFE -> delay of tbl_data[7:0]*DELAY_UNIT cycles.
- States:
  - IDLE: start -> BOOT; counter=BOOT_WAIT, tbl_addr=0, retry=0, done=0, err=0, busy=1.
  - BOOT: decrement each cycle; at 0 -> FETCH.
  - FETCH: one cycle, tbl_addr stable -> DECODE.
  - DECODE: end marker -> DONE. Delay marker: count 0 -> advance; else load counter, -> DELAY. Otherwise latch wr_reg/wr_data, set wr_req=1 -> WAIT.
  - WAIT: hold wr_req and payload. wr_done&!wr_nack -> wr_req=0, retry=0, advance. wr_done&wr_nack -> wr_req=0; retry<MAX_RETRY: retry+1, counter=GAP_CYCLES, -> GAP (same index); else err_index=tbl_addr -> ERROR.
  - DELAY: count down exactly data*DELAY_UNIT cycles, then advance without gap.
  - GAP: GAP_CYCLES cycles, then FETCH.
  - advance: if tbl_addr==2**ADDR_W-1 -> DONE (no wrap); else tbl_addr+1; after write -> GAP, after delay/zero delay -> FETCH.
  - DONE: done=1, busy=0; start -> BOOT (clears done).
  - ERROR: err=1, busy=0, wr_req=0; start -> BOOT (clears err, err_index retained until then).
- Latency: first wr_req rises BOOT_WAIT+3 edges after the edge sampling start.
- wr_done outside WAIT ignored. start while busy ignored.
- Counter width: $clog2(255*DELAY_UNIT+1), at least $clog2(BOOT_WAIT+1); product computed at that width, no truncation.

Decomposition:
- Package cam_cfg_pkg: state encoding, END_MARKER 24'hFFFFFF, DELAY_TAG 16'hFFFE, entry field slices.
- Sub-module cfg_timer: loadable down-counter with zero flag, shared by BOOT, DELAY and GAP.

Test Plan:
- BOOT_WAIT=10, table {0x1234AB, 0x0011CD, END}, master acks: wr_req at start+13 with reg 0x1234 data 0xAB; after GAP of 4 cycles, second write 0x0011/0xCD; then done=1, busy=0, exactly 2 requests.
- Insert 0xFFFE05 between the writes, DELAY_UNIT=8: second wr_req rises exactly 42 cycles later than without the entry; no request for the marker.
- MAX_RETRY=3, first entry NACKed twice then acked: 3 requests with identical payload, 4-cycle gaps, then advance; done=1, err=0.
- First entry NACKed 4 times: 4 requests, then err=1, err_index=0, busy=0, wr_req=0, no further requests; start restarts from index 0.
- Reset asserted during WAIT: wr_req and busy fall asynchronously; after release, start re-runs from tbl_addr=0.
- ADDR_W=2, table with no END marker, all acked: 4 writes then done=1 with tbl_addr=3; start pulse during busy has no effect.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: states, table markers and entry field helpers for the camera config sequencer
package cam_cfg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_BOOT, S_FETCH, S_DECODE, S_WAIT, S_DELAY, S_GAP, S_DONE, S_ERROR
  } state_t;
  localparam logic [23:0] END_MARKER = 24'hFFFFFF;
  localparam logic [15:0] DELAY_TAG = 16'hFFFE;
  function automatic logic [15:0] entry_reg(input logic [23:0] e);
    return e[23:8];
  endfunction
  function automatic logic [7:0] entry_data(input logic [23:0] e);
    return e[7:0];
  endfunction
  function automatic logic is_end(input logic [23:0] e);
    return e == END_MARKER;
  endfunction
  function automatic logic is_delay(input logic [23:0] e);
    return e[23:8] == DELAY_TAG;
  endfunction
endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// cam_cfg_sequencer_if: byte-write request bus between the sequencer and the SCCB/I2C master
interface cam_cfg_sequencer_if;
  logic wr_req;
  logic [6:0] wr_dev;
  logic [15:0] wr_reg;
  logic [7:0] wr_data;
  logic wr_done;
  logic wr_nack;
  modport master(output wr_req, wr_dev, wr_reg, wr_data, input wr_done, wr_nack);
  modport slave(input wr_req, wr_dev, wr_reg, wr_data, output wr_done, wr_nack);
endinterface

// File: rtl/cam_cfg_sequencer_timer.sv
// cfg_timer: loadable down-counter with zero flag, shared by boot, delay and gap waits
module cfg_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (ld) cnt <= val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks the sensor register table and issues one bus write per entry
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter logic [6:0] DEV_ADDR = 7'h12,
  parameter int BOOT_WAIT = 1000,
  parameter int DELAY_UNIT = 1000,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  cam_cfg_sequencer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_index
);
  localparam int CW_D = $clog2(255 * DELAY_UNIT + 1);
  localparam int CW_B = $clog2(BOOT_WAIT + 1);
  localparam int CW_G = $clog2(GAP_CYCLES + 1);
  localparam int CW = CW_D > CW_B ? (CW_D > CW_G ? CW_D : CW_G) : (CW_B > CW_G ? CW_B : CW_G);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_LD = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  state_t state;
  logic [RW-1:0] retry;
  logic t_ld, t_dec, t_zero, restart, ack, nack, adv, last, dly_zero;
  logic [CW-1:0] t_val;
  logic [7:0] dcnt;
  cfg_timer #(.W(CW)) u_timer (
    .clk (clk),
    .rst (rst),
    .ld  (t_ld),
    .dec (t_dec),
    .val (t_val),
    .zero(t_zero)
  );
  assign bus.wr_dev = DEV_ADDR;
  // Delay and gap reloads are one short so those states last exactly their count in cycles
  always_comb begin
    dcnt = entry_data(tbl_data);
    dly_zero = dcnt == 8'd0;
    restart = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    ack = state == S_WAIT && bus.wr_done && !bus.wr_nack;
    nack = state == S_WAIT && bus.wr_done && bus.wr_nack;
    last = tbl_addr == '1;
    adv = ack || (state == S_DELAY && t_zero)
        || (state == S_DECODE && !is_end(tbl_data) && is_delay(tbl_data) && dly_zero);
    t_ld = restart || (state == S_WAIT && bus.wr_done)
        || (state == S_DECODE && !is_end(tbl_data) && is_delay(tbl_data) && !dly_zero);
    t_val = restart ? CW'(BOOT_WAIT)
          : state == S_DECODE ? CW'(dcnt) * CW'(DELAY_UNIT) - 1'b1
          : CW'(GAP_LD);
    t_dec = state == S_BOOT || state == S_DELAY || state == S_GAP;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      tbl_addr <= '0;
      bus.wr_req <= 1'b0;
      bus.wr_reg <= '0;
      bus.wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_index <= '0;
      retry <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (start) begin
            state <= S_BOOT;
            tbl_addr <= '0;
            retry <= '0;
            done <= 1'b0;
            err <= 1'b0;
            busy <= 1'b1;
          end
        S_BOOT: if (t_zero) state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE:
          if (is_end(tbl_data)) begin
            state <= S_DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else if (is_delay(tbl_data)) state <= dly_zero ? S_FETCH : S_DELAY;
          else begin
            bus.wr_reg <= entry_reg(tbl_data);
            bus.wr_data <= dcnt;
            bus.wr_req <= 1'b1;
            state <= S_WAIT;
          end
        S_WAIT:
          if (ack) begin
            bus.wr_req <= 1'b0;
            retry <= '0;
            state <= S_GAP;
          end else if (nack) begin
            bus.wr_req <= 1'b0;
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= S_GAP;
            end else begin
              err_index <= tbl_addr;
              err <= 1'b1;
              busy <= 1'b0;
              state <= S_ERROR;
            end
          end
        S_DELAY: if (t_zero) state <= S_FETCH;
        S_GAP: if (t_zero) state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
      // Advancing past the last index finishes instead of wrapping
      if (adv) begin
        if (last) begin
          state <= S_DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end else tbl_addr <= tbl_addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: table-driven scenarios against a registered ROM and an acking write slave
module tb_cam_cfg_sequencer;
  localparam int ADDR_W = 2;
  typedef struct {
    logic [23:0] tbl[4];
    int nacks, reqs, dn, er, eidx, addr, lat, reg0, dat0, gap2, reg1, dat1;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, busy, done, err;
  logic [ADDR_W-1:0] tbl_addr, err_index;
  logic [23:0] tbl_data = '0;
  logic [23:0] rom[4] = '{default: '0};
  logic hold_ack = 1'b0;
  int cyc = 0, req_cnt = 0, nack_upto = 0, nvec = 0, nerr = 0;
  int rise[64];
  int rreg[64];
  int rdat[64];
  vec_t vecs[6];
  cam_cfg_sequencer_if bus ();
  cam_cfg_sequencer #(
    .ADDR_W(ADDR_W), .DEV_ADDR(7'h12), .BOOT_WAIT(10),
    .DELAY_UNIT(8), .GAP_CYCLES(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .bus(bus.master), .busy(busy), .done(done), .err(err), .err_index(err_index)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_data <= rom[tbl_addr];
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wr_req && !prev && req_cnt < 64) begin
        rise[req_cnt] = cyc;
        rreg[req_cnt] = int'(bus.wr_reg);
        rdat[req_cnt] = int'(bus.wr_data);
        req_cnt++;
      end
      prev = bus.wr_req;
    end
  end
  initial begin
    bus.wr_done = 1'b0;
    bus.wr_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && bus.wr_req && !hold_ack) begin
        repeat (2) @(posedge clk);
        #1;
        bus.wr_nack = req_cnt <= nack_upto;
        bus.wr_done = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_done = 1'b0;
        bus.wr_nack = 1'b0;
      end
    end
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input int poke);
    int base, s, n;
    for (int i = 0; i < 4; i++) rom[i] = v.tbl[i];
    base = req_cnt;
    nack_upto = base + v.nacks;
    @(posedge clk);
    #1;
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk("idle_reached", busy, 0);
    chk("req_count", req_cnt - base, v.reqs);
    chk("done", done, v.dn);
    chk("err", err, v.er);
    if (v.er != 0) chk("err_index", err_index, v.eidx);
    chk("tbl_addr_final", tbl_addr, v.addr);
    chk("wr_req_final", bus.wr_req, 0);
    chk("wr_dev", bus.wr_dev, 'h12);
    if (v.reqs > 0 && req_cnt > base) begin
      chk("first_latency", rise[base] - s, v.lat);
      chk("reg0", rreg[base], v.reg0);
      chk("dat0", rdat[base], v.dat0);
    end
    if (v.reqs > 1 && req_cnt > base + 1) begin
      chk("second_spacing", rise[base+1] - rise[base], v.gap2);
      chk("reg1", rreg[base+1], v.reg1);
      chk("dat1", rdat[base+1], v.dat1);
    end
  endtask
  initial begin
    int n;
    vecs[0] = '{'{24'h1234AB, 24'h0011CD, 24'hFFFFFF, 24'h0}, 0, 2, 1, 0, 0, 2, 13, 'h1234, 'hAB, 9, 'h0011, 'hCD};
    vecs[1] = '{'{24'h1234AB, 24'hFFFE05, 24'h0011CD, 24'hFFFFFF}, 0, 2, 1, 0, 0, 3, 13, 'h1234, 'hAB, 51, 'h0011, 'hCD};
    vecs[2] = '{'{24'h1234AB, 24'h0011CD, 24'hFFFFFF, 24'h0}, 2, 4, 1, 0, 0, 2, 13, 'h1234, 'hAB, 9, 'h1234, 'hAB};
    vecs[3] = '{'{24'h1234AB, 24'h0011CD, 24'hFFFFFF, 24'h0}, 4, 4, 0, 1, 0, 0, 13, 'h1234, 'hAB, 9, 'h1234, 'hAB};
    vecs[4] = '{'{24'h1234AB, 24'h0011CD, 24'h5555AA, 24'h7777BB}, 0, 4, 1, 0, 0, 3, 13, 'h1234, 'hAB, 9, 'h0011, 'hCD};
    vecs[5] = '{'{24'hFFFE00, 24'h1234AB, 24'hFFFFFF, 24'h0}, 0, 1, 1, 0, 0, 2, 15, 'h1234, 'hAB, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_wr_reg", bus.wr_reg, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_index", err_index, 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], 0);
    run_vec(vecs[4], 30);
    hold_ack = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!bus.wr_req && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_before_reset", bus.wr_req, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_wr_req", bus.wr_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tbl_addr", tbl_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold_ack = 1'b0;
    run_vec(vecs[0], 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
